// File: rtl/front_panel_pkg.sv
// Shared event types and the CPU-facing event_data packing for the front-panel encoder block.
package front_panel_pkg;

    typedef enum logic [1:0] {
        EV_CW      = 2'b00,
        EV_CCW     = 2'b01,
        EV_PRESS   = 2'b10,
        EV_RELEASE = 2'b11
    } ev_type_e;

    typedef struct packed {
        logic [2:0] channel;
        ev_type_e   kind;
    } event_t;

    function automatic logic [7:0] pack_event(event_t ev);
        return {3'b000, ev.kind, ev.channel};
    endfunction

endpackage

// File: rtl/enc_channel.sv
// One encoder channel: synchronise and debounce A/B/switch, quadrature-decode into
// detent steps, track the wrapping position and flag switch edges.
module enc_channel
    import front_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 1000,
    parameter int unsigned STEPS_PER_DETENT = 4,
    parameter int unsigned COUNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               raw_a,
    input  logic               raw_b,
    input  logic               raw_sw,
    input  logic               count_clear,
    output logic               step,
    output logic               step_ccw,
    output logic               sw_press,
    output logic               sw_release,
    output logic [COUNT_W-1:0] pos_count
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0] DET     = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] DET_NEG = -DET;

    logic [2:0]       raw, sync1, sync2, deb;
    logic [CNT_W-1:0] cnt [3];
    logic [1:0]       quad;
    logic             sw_q;
    logic signed [3:0] acc, acc_inc;
    logic [1:0]       idx_old, idx_new, delta;
    logic             fwd, rev;

    assign raw = {raw_sw, raw_b, raw_a};

    // Debounced bit adopts sync2 once it has differed from it for DEBOUNCE_CYCLES stable cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else if (sync1[i] != sync2[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Gray position index: 00->0, 01->1, 11->2, 10->3; a delta of 2 is an invalid jump.
    always_comb begin
        idx_old  = {quad[1], quad[1] ^ quad[0]};
        idx_new  = {deb[1], deb[1] ^ deb[0]};
        delta    = idx_new - idx_old;
        fwd      = (delta == 2'd1);
        rev      = (delta == 2'd3);
        acc_inc  = acc;
        if (fwd) acc_inc = acc + 4'sd1;
        if (rev) acc_inc = acc - 4'sd1;
        step     = (fwd && acc_inc == DET) || (rev && acc_inc == DET_NEG);
        step_ccw = rev && acc_inc == DET_NEG;
        sw_press   = deb[2] & ~sw_q;
        sw_release = ~deb[2] & sw_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quad      <= '0;
            sw_q      <= 1'b0;
            acc       <= '0;
            pos_count <= '0;
        end else begin
            quad <= deb[1:0];
            sw_q <= deb[2];
            acc  <= step ? 4'sd0 : acc_inc;
            if (count_clear) begin
                pos_count <= '0;
            end else if (step) begin
                if (step_ccw) pos_count <= pos_count - 1'b1;
                else          pos_count <= pos_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/front_panel_encoders.sv
// Multi-channel encoder front panel: per-channel pending flags, fixed-priority arbiter
// and a first-word-fall-through event FIFO drained by the CPU.
module front_panel_encoders
    import front_panel_pkg::*;
#(
    parameter int unsigned NUM_ENC          = 4,
    parameter int unsigned DEBOUNCE_CYCLES  = 1000,
    parameter int unsigned STEPS_PER_DETENT = 4,
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned COUNT_W          = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_ENC-1:0]         encoder_A,
    input  logic [NUM_ENC-1:0]         encoder_B,
    input  logic [NUM_ENC-1:0]         encoder_sw,
    input  logic [NUM_ENC-1:0]         count_clear,
    input  logic                       event_rd_stb,
    input  logic                       overflow_clr,
    output logic                       event_valid,
    output logic [7:0]                 event_data,
    output logic                       overflow,
    output logic [NUM_ENC*COUNT_W-1:0] pos_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_ENC-1:0] step, step_ccw, sw_press, sw_release, sw_new;
    logic [NUM_ENC-1:0] rot_pend, rot_ccw, sw_pend, sw_rel;
    logic [NUM_ENC-1:0] grant_sw, grant_rot;
    logic               found, push, pop, empty, full, drop;
    event_t             head_in;
    event_t             mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;

    for (genvar g = 0; g < NUM_ENC; g++) begin : g_ch
        enc_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STEPS_PER_DETENT(STEPS_PER_DETENT),
            .COUNT_W         (COUNT_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw_a      (encoder_A[g]),
            .raw_b      (encoder_B[g]),
            .raw_sw     (encoder_sw[g]),
            .count_clear(count_clear[g]),
            .step       (step[g]),
            .step_ccw   (step_ccw[g]),
            .sw_press   (sw_press[g]),
            .sw_release (sw_release[g]),
            .pos_count  (pos_count[g*COUNT_W +: COUNT_W])
        );
    end

    assign sw_new = sw_press | sw_release;
    assign drop   = |(sw_new & sw_pend) | |(step & rot_pend);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop   = event_rd_stb && !empty;

    always_comb begin
        found     = 1'b0;
        grant_sw  = '0;
        grant_rot = '0;
        head_in   = '{channel: 3'd0, kind: EV_CW};
        for (int unsigned i = 0; i < NUM_ENC; i++) begin
            if (!found && sw_pend[i]) begin
                found       = 1'b1;
                grant_sw[i] = 1'b1;
                head_in     = '{channel: 3'(i), kind: (sw_rel[i] ? EV_RELEASE : EV_PRESS)};
            end else if (!found && rot_pend[i]) begin
                found        = 1'b1;
                grant_rot[i] = 1'b1;
                head_in      = '{channel: 3'(i), kind: (rot_ccw[i] ? EV_CCW : EV_CW)};
            end
        end
        // A simultaneous pop frees the slot, so a full FIFO can still accept this cycle.
        push = found && (!full || pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rot_pend <= '0;
            rot_ccw  <= '0;
            sw_pend  <= '0;
            sw_rel   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENC; i++) begin
                if (push && grant_sw[i]) begin
                    sw_pend[i] <= 1'b0;
                end else if (sw_new[i] && !sw_pend[i]) begin
                    sw_pend[i] <= 1'b1;
                    sw_rel[i]  <= sw_release[i];
                end
                if (push && grant_rot[i]) begin
                    rot_pend[i] <= 1'b0;
                end else if (step[i] && !rot_pend[i]) begin
                    rot_pend[i] <= 1'b1;
                    rot_ccw[i]  <= step_ccw[i];
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= head_in;
    end

    always_comb begin
        event_valid = !empty;
        event_data  = empty ? 8'h00 : pack_event(mem[rd_ptr[PTR_W-1:0]]);
    end

endmodule

// File: tb/tb_front_panel_encoders.sv
// Randomised and directed bench for front_panel_encoders against a detent/queue-level model.
module tb_front_panel_encoders;

    localparam int unsigned N = 4, D = 4, S = 4, DEPTH = 8, CW = 8;
    localparam int MODV = 1 << CW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] encoder_A = '0, encoder_B = '0, encoder_sw = '0, count_clear = '0;
    logic event_rd_stb = 1'b0, overflow_clr = 1'b0;
    logic event_valid, overflow;
    logic [7:0] event_data;
    logic [N*CW-1:0] pos_count;

    int total = 0;
    int bad = 0;

    logic [1:0] m_ab  [N];
    int         m_acc [N];
    int         m_pos [N];
    logic       m_sw  [N];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    front_panel_encoders #(
        .NUM_ENC(N), .DEBOUNCE_CYCLES(D), .STEPS_PER_DETENT(S),
        .FIFO_DEPTH(DEPTH), .COUNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .encoder_A(encoder_A), .encoder_B(encoder_B), .encoder_sw(encoder_sw),
        .count_clear(count_clear), .event_rd_stb(event_rd_stb), .overflow_clr(overflow_clr),
        .event_valid(event_valid), .event_data(event_data), .overflow(overflow),
        .pos_count(pos_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick(int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int unsigned qidx(logic [1:0] ba);
        case (ba)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] qval(int unsigned idx);
        case (idx % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [7:0] ev_byte(int unsigned ch, int unsigned kind);
        return 8'((kind << 3) | ch);
    endfunction

    function automatic logic [1:0] cw_next(int unsigned ch);
        return qval(qidx(m_ab[ch]) + 1);
    endfunction

    function automatic logic [1:0] ccw_next(int unsigned ch);
        return qval(qidx(m_ab[ch]) + 3);
    endfunction

    // Raw input change that is held long enough to pass the debouncer.
    task automatic drive_ab(int unsigned ch, logic [1:0] ab);
        int unsigned d;
        encoder_B[ch] = ab[1];
        encoder_A[ch] = ab[0];
        d = (qidx(ab) + 4 - qidx(m_ab[ch])) % 4;
        if (d == 1) m_acc[ch]++;
        else if (d == 3) m_acc[ch]--;
        if (m_acc[ch] == int'(S)) begin
            m_acc[ch] = 0;
            m_pos[ch] = (m_pos[ch] + 1) % MODV;
            exp_q.push_back(ev_byte(ch, 0));
        end else if (m_acc[ch] == -int'(S)) begin
            m_acc[ch] = 0;
            m_pos[ch] = (m_pos[ch] + MODV - 1) % MODV;
            exp_q.push_back(ev_byte(ch, 1));
        end
        m_ab[ch] = ab;
    endtask

    task automatic drive_sw(int unsigned ch, logic v);
        encoder_sw[ch] = v;
        if (v != m_sw[ch]) exp_q.push_back(ev_byte(ch, v ? 2 : 3));
        m_sw[ch] = v;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < int'(N); i++) begin
            m_ab[i] = 2'b00; m_acc[i] = 0; m_pos[i] = 0; m_sw[i] = 1'b0;
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        got_q.delete();
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!event_valid) begin
                done = 1;
            end else begin
                got_q.push_back(event_data);
                event_rd_stb = 1'b1;
                @(posedge clk);
                #1;
                event_rd_stb = 1'b0;
            end
        end
        if (done) tick(1);
    endtask

    task automatic test_reset();
        model_reset();
        tick(3);
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", event_valid); end
        total++; if (event_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", event_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (pos_count !== '0) begin bad++; $display("FAIL reset_pos got=%h exp=0", pos_count); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_cw_detent();
        int first;
        drive_ab(2, 2'b01); tick(10);
        drive_ab(2, 2'b11); tick(10);
        drive_ab(2, 2'b10); tick(10);
        drive_ab(2, 2'b00);
        first = -1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (event_valid && first < 0) first = k;
        end
        tick(1);
        total++; if (first != int'(D) + 4) begin bad++; $display("FAIL cw_latency got=%0d exp=%0d", first, D + 4); end
        drain();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h02) begin
            bad++; $display("FAIL cw_event got=%p exp='{02}", got_q);
        end
        total++; if (pos_count[2*CW +: CW] !== 8'h01) begin bad++; $display("FAIL cw_pos got=%h exp=01", pos_count[2*CW +: CW]); end
        exp_q.delete();
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 10; k++) begin
            encoder_A[0] = ~encoder_A[0];
            tick(2);
        end
        tick(20);
        total++; if (event_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL bounce_valid got=%b exp=0", event_valid); end
        total++; if (pos_count[0 +: CW] !== 8'(m_pos[0])) begin bad++; $display("FAIL bounce_pos got=%h exp=%h", pos_count[0 +: CW], 8'(m_pos[0])); end
        drive_ab(0, 2'b11); tick(15);
        total++; if (event_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL jump_valid got=%b exp=%b", event_valid, exp_q.size() != 0); end
        total++; if (pos_count[0 +: CW] !== 8'(m_pos[0])) begin bad++; $display("FAIL jump_pos got=%h exp=%h", pos_count[0 +: CW], 8'(m_pos[0])); end
        drive_ab(0, 2'b00); tick(15);
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL jump_events got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        // Same-cycle events: model push order follows channel priority.
        drive_sw(0, 1'b1); drive_sw(3, 1'b1);
        tick(14);
        drain();
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL sim_press_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sim_press[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
        drive_sw(0, 1'b0); drive_sw(3, 1'b0);
        tick(14);
        drain();
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL sim_rel_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL sim_rel[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_fifo_full();
        for (int c = 0; c < int'(N); c++) drive_sw(c, 1'b1);
        tick(16);
        for (int c = 0; c < int'(N); c++) drive_sw(c, 1'b0);
        tick(16);
        drive_sw(0, 1'b1);
        tick(16);
        total++; if (event_data !== exp_q[0]) begin bad++; $display("FAIL full_head got=%h exp=%h", event_data, exp_q[0]); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
        drive_sw(0, 1'b0);
        void'(exp_q.pop_back());  // switch flag on ch0 still pending: this release is lost
        tick(16);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", overflow); end
        total++; if (event_data !== exp_q[0]) begin bad++; $display("FAIL full_head2 got=%h exp=%h", event_data, exp_q[0]); end
        void'(exp_q.pop_front());
        event_rd_stb = 1'b1; tick(1); event_rd_stb = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_drain_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_wrap_clear();
        for (int det = 0; det < 128; det++) begin
            for (int q = 0; q < 4; q++) begin drive_ab(1, cw_next(1)); tick(9); end
            drain();
            total++;
            if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
                bad++; $display("FAIL wrap_det%0d got=%p exp=%p", det, got_q, exp_q);
            end
            exp_q.delete();
        end
        total++; if (pos_count[CW +: CW] !== 8'h80) begin bad++; $display("FAIL wrap_80 got=%h exp=80", pos_count[CW +: CW]); end
        for (int q = 0; q < 4; q++) begin drive_ab(1, ccw_next(1)); tick(9); end
        drain();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h09) begin bad++; $display("FAIL ccw_event got=%p exp='{09}", got_q); end
        total++; if (pos_count[CW +: CW] !== 8'h7F) begin bad++; $display("FAIL wrap_7f got=%h exp=7f", pos_count[CW +: CW]); end
        exp_q.delete();
        for (int q = 0; q < 3; q++) begin drive_ab(1, cw_next(1)); tick(9); end
        drive_ab(1, cw_next(1));
        tick(D + 2);
        count_clear[1] = 1'b1; tick(1); count_clear[1] = 1'b0;
        m_pos[1] = 0;
        tick(5);
        drain();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 8'h01) begin bad++; $display("FAIL clear_event got=%p exp='{01}", got_q); end
        total++; if (pos_count[CW +: CW] !== 8'(m_pos[1])) begin bad++; $display("FAIL clear_pos got=%h exp=00", pos_count[CW +: CW]); end
        exp_q.delete();
    endtask

    task automatic test_random();
        int unsigned ch, act;
        for (int it = 0; it < 60; it++) begin
            ch  = $urandom_range(0, N - 1);
            act = $urandom_range(0, 3);
            case (act)
                0: drive_ab(ch, cw_next(ch));
                1: drive_ab(ch, ccw_next(ch));
                2: drive_sw(ch, ~m_sw[ch]);
                default: drive_ab(ch, m_ab[ch] ^ 2'b11);
            endcase
            tick(12);
            drain();
            total++;
            if (got_q.size() != exp_q.size() || (exp_q.size() != 0 && got_q[0] !== exp_q[0])) begin
                bad++; $display("FAIL rand_ev it=%0d got=%p exp=%p", it, got_q, exp_q);
            end
            exp_q.delete();
            for (int c = 0; c < int'(N); c++) begin
                total++;
                if (pos_count[c*CW +: CW] !== 8'(m_pos[c])) begin
                    bad++; $display("FAIL rand_pos it=%0d ch=%0d got=%h exp=%h", it, c, pos_count[c*CW +: CW], 8'(m_pos[c]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < int'(N); c++) begin drive_sw(c, 1'b0); drive_ab(c, 2'b00); end
        tick(16);
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL norm_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        exp_q.delete();
        drive_sw(0, 1'b1); drive_sw(1, 1'b1); drive_sw(2, 1'b1);
        tick(14);
        drive_sw(3, 1'b1);
        tick(D + 3);
        reset_n = 1'b0;
        #1;
        total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", event_valid); end
        encoder_A = '0; encoder_B = '0; encoder_sw = '0;
        encoder_sw[0] = 1'b1;
        model_reset();
        tick(3);
        reset_n = 1'b1;
        drive_sw(0, 1'b1);
        tick(16);
        drain();
        total++;
        if (got_q.size() != exp_q.size() || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            bad++; $display("FAIL midrst_events got=%p exp=%p", got_q, exp_q);
        end
        total++; if (pos_count !== '0) begin bad++; $display("FAIL midrst_pos got=%h exp=0", pos_count); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_cw_detent();
        test_bounce();
        test_simultaneous();
        test_fifo_full();
        test_wrap_clear();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/front_panel_encoders.md
# front_panel_encoders

Parametrised multi-channel front-panel input block. It debounces and quadrature-decodes up to 8 rotary encoders with push switches and keeps a wrapping position count per channel. Rotation and switch events go into one FIFO that the CPU drains by strobe, so no event is lost between reads. This block replaces the single-encoder, single-register front-panel path and sits between the panel pins and the CPU register file.

## Interface
- NUM_ENC, 4: encoder channels, 1..8
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles before a debounced input updates, ≥2
- STEPS_PER_DETENT, 4: quadrature transitions per reported step, one of 1/2/4
- FIFO_DEPTH, 8: event FIFO entries, power of 2, ≥2
- COUNT_W, 8: position counter width per channel
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- encoder_A  in  NUM_ENC  raw quadrature A per channel, asynchronous
- encoder_B  in  NUM_ENC  raw quadrature B per channel, asynchronous
- encoder_sw  in  NUM_ENC  raw push switch per channel, 1 = pressed
- count_clear  in  NUM_ENC  per-channel position clear strobe
- event_rd_stb  in  1  pops the FIFO head
- overflow_clr  in  1  clears the sticky overflow flag
- event_valid  out  1  FIFO not empty
- event_data  out  8  FIFO head: [2:0] channel, [4:3] type (00 CW, 01 CCW, 10 press, 11 release), [7:5] 0
- overflow  out  1  sticky: at least one event was dropped
- pos_count  out  NUM_ENC*COUNT_W  per-channel two's-complement position; channel i occupies [i*COUNT_W +: COUNT_W]

## Operation
- **Input conditioning.** Each raw input passes through a 2-flop synchroniser and then a debounce counter. The counter resets on any change of the synchronised value. The debounced value takes the synchronised value when the counter reaches DEBOUNCE_CYCLES.
- **Quadrature decode.**
  - Clockwise sequence on debounced {B,A] is 00→01→11→10→00. Counter-clockwise is the reverse.
  - Each valid transition adds +1 (CW) or −1 (CCW) to a signed sub-step accumulator of 4 bits.
  - A transition where both bits change is invalid: the state is updated, the accumulator is unchanged, and no event is raised.
  - When the accumulator reaches +STEPS_PER_DETENT, a CW step fires and the accumulator returns to 0. At −STEPS_PER_DETENT, a CCW step fires and the accumulator returns to 0.
- **Switch events.** A debounced switch rising edge raises a press event; a falling edge raises a release event.
- **Position count.**
  - A CW step increments pos_count of that channel and a CCW step decrements it, in the same cycle the step fires.
  - The count wraps modulo 2^COUNT_W.
  - count_clear[i] forces the count to 0. If a clear coincides with a step, the clear wins, but the step event is still queued.
- **Pending flags.**
  - Each channel holds one rotation-pending flag (with its direction) and one switch-pending flag (with its type).
  - If a new event arrives while the same-kind flag is still set, the new event is dropped and overflow is set.
- **Arbiter.**
  - Pushes at most one pending event per cycle, then clears that flag.
  - Priority: lowest channel first; within a channel, switch before rotation.
  - No push happens while the FIFO is full; flags wait.
- **FIFO.** First-word-fall-through. event_rd_stb while event_valid pops one entry. event_rd_stb while empty is ignored. A push and a pop in the same cycle are both honoured, including when the FIFO is full, so occupancy stays unchanged.
- **Overflow.** Stays set until overflow_clr. If overflow_clr and a new drop occur in the same cycle, the flag stays set.

## Timing
- **Reset values.**
  - Synchronisers, debounced values, decode state, accumulators, pos_count, pending flags, FIFO pointers and overflow are all 0.
  - Outputs: event_valid=0, event_data=0.
- **Reset mid-operation.** Discards queued and pending events immediately.
- **Post-reset behaviour.** An encoder resting at 11 yields 00→11, which is an invalid transition: no event. A switch held down through reset yields one press event after debounce.
- **Latency.** The last raw edge in cycle 0 gives event_valid=1 in cycle DEBOUNCE_CYCLES+4 with an empty FIFO and no competing pending events. Stages:
  - 2 cycles synchroniser
  - DEBOUNCE_CYCLES cycles debounce
  - 1 cycle decode/pending
  - 1 cycle push
- **Pop timing.** event_data updates in the cycle after a pop.
- **Throughput.** Sustained throughput is 1 event per cycle.

## Structure
- front_panel_pkg holds:
  - event type enum (EV_CW, EV_CCW, EV_PRESS, EV_RELEASE)
  - packed event struct {channel[2:0], type[1:0]}
  - the event_data packing function
- Sub-module enc_channel holds everything per channel: synchronisers, 3 debouncers, quadrature decoder, sub-step accumulator and position counter. It exports step/direction and switch-edge strobes. The top level generates NUM_ENC instances plus the pending flags, arbiter and FIFO.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4, NUM_ENC=4, FIFO_DEPTH=8.
- **Single CW detent.** Drive channel 2 through one full CW sequence with 10-cycle phases. Expect exactly one event 0x02, pos_count[2]=1, and event_valid in cycle 8 after the final edge.
- **Bounce and invalid transitions.**
  - A toggles every 2 cycles for 20 cycles, then rests: no events.
  - A 00→11 jump: no event and pos_count unchanged.
- **Simultaneous events.** Channels 0 and 3 press in the same cycle. Expect event 0x10 popped first, then 0x13, then release events later.
- **FIFO full.**
  - Queue 8 events without reading; a 9th waits as pending and overflow stays 0.
  - A 10th of the same kind is dropped and sets overflow=1.
  - Popping one admits the 9th; overflow_clr then gives overflow=0.
- **Wrap and clear.**
  - 128 CW detents on channel 1 give pos_count[1]=0x80. One CCW gives 0x7F.
  - count_clear coincident with a step gives 0, with the event still queued.
- **Reset mid-operation.** Assert reset_n=0 with 3 queued events and a pending press. Expect event_valid=0 immediately. After release, no stale events appear and all counts read 0.
